cu_fsm_mc: RTL
==============

CU_FSM_MC -- requirements
Module: cu_fsm_mc

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, legal range 1..8: memory read latency in clock cycles for both instruction and data ports.
REQ-002 The block SHALL have port CLK  input  1  single system clock, all state changes on rising edge.
REQ-003 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port CU_OPCODE  input  7  opcode field of the current instruction, stable from the end of FETCH until FETCH is re-entered.
REQ-005 The block SHALL have port INT  input  1  level interrupt request.
REQ-006 The block SHALL have port CSR_MIE  input  1  global interrupt enable.
REQ-007 The block SHALL have outputs PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WRITE, INT_TAKEN and ILLEGAL_OP, each output 1 bit, with these meanings:
- PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2: datapath strobes.
- CSR_WRITE: SYSTEM-instruction CSR update.
- INT_TAKEN: PC mux selects trap vector.
- ILLEGAL_OP: unrecognised opcode.

Function
REQ-008 The state machine SHALL have the states FETCH, EXEC, WRITEBACK and TRAP, with a wait counter of width clog2(MEM_LAT)+1.
REQ-009 FETCH SHALL last exactly MEM_LAT cycles with MEM_READ1=1 in every cycle, then go to EXEC with the counter cleared.
REQ-010 EXEC SHALL last one cycle and decode the opcode as follows:
- LUI/AUIPC/JAL/JALR/OP/OP_IMM: REG_WRITE=1, PC_WRITE=1.
- BRANCH: PC_WRITE=1.
- STORE: MEM_WRITE=1, PC_WRITE=1.
- SYSTEM (1110011): CSR_WRITE=1, REG_WRITE=1, PC_WRITE=1.
- LOAD: MEM_READ2=1, PC_WRITE=0.
REQ-011 Any other opcode in EXEC SHALL assert ILLEGAL_OP=1 and PC_WRITE=1 for that cycle, with no register, memory or CSR write.
REQ-012 From EXEC, a LOAD SHALL go to WRITEBACK; every other opcode is a completing cycle.
REQ-013 WRITEBACK SHALL last MEM_LAT cycles:
- Cycles 1..MEM_LAT-1: MEM_READ2=1.
- Final cycle: REG_WRITE=1, PC_WRITE=1; this is the completing cycle.
REQ-014 Every output not listed as asserted for the current state and cycle SHALL be 0.
REQ-015 The interrupt condition SHALL be INT & CSR_MIE, evaluated only on a completing cycle: true goes to TRAP, false goes to FETCH.
REQ-016 INT asserted and deasserted entirely between completing cycles SHALL be ignored (no latching).
REQ-017 TRAP SHALL last one cycle with INT_TAKEN=1 and PC_WRITE=1, then go to FETCH.
REQ-018 TRAP SHALL never chain into a second TRAP, even with INT still high.
REQ-019 With MEM_LAT=1, instruction latency SHALL be 2 cycles for non-load and 3 cycles for LOAD, plus 1 cycle for TRAP.

Reset
REQ-020 RST assertion SHALL force state FETCH and counter 0 immediately, regardless of CLK.
REQ-021 While RST is high, all outputs SHALL be 0.
REQ-022 An instruction interrupted by reset mid-FETCH or mid-WRITEBACK SHALL be abandoned without any write strobe.
REQ-023 The first rising edge after RST deasserts SHALL be cycle 1 of FETCH.

Configuration
REQ-024 With macro CU_INTERRUPT_EN defined, the TRAP state and the behaviour of REQ-015..REQ-018 SHALL be present.
REQ-025 Without CU_INTERRUPT_EN, TRAP SHALL not exist, INT and CSR_MIE SHALL be ignored, INT_TAKEN SHALL be tied 0, and completing cycles SHALL always go to FETCH.

Structure
REQ-026 The opcode enum (including SYSTEM) and the state enum SHALL live in shared package otter_pkg.
REQ-027 The wait counter SHALL be the sub-module cu_wait_cnt, with these ports:
- inputs: CLK, RST, clear, enable.
- outputs: count, done = (count == MEM_LAT-1).

Verification
REQ-028 MEM_LAT=1, opcode OP: FETCH (MEM_READ1=1) -> next cycle REG_WRITE=1, PC_WRITE=1 -> FETCH; 2 cycles total.
REQ-029 MEM_LAT=3, opcode LOAD: the bench SHALL observe this cycle sequence:
- Cycles 1-3: MEM_READ1=1.
- Cycle 4: MEM_READ2=1.
- Cycles 5-6: MEM_READ2=1.
- Cycle 7: REG_WRITE=1, PC_WRITE=1.
REQ-030 CU_INTERRUPT_EN defined, INT=1 and CSR_MIE=1 during a STORE EXEC: MEM_WRITE=1 and PC_WRITE=1, then one TRAP cycle with INT_TAKEN=1, then FETCH. The next completing cycle with INT held high SHALL again enter TRAP.
REQ-031 INT=1 with CSR_MIE=0, and separately an INT pulse only during FETCH: INT_TAKEN stays 0 throughout.
REQ-032 Opcode 0000000 in EXEC: ILLEGAL_OP=1, PC_WRITE=1, REG_WRITE=MEM_WRITE=CSR_WRITE=0.
REQ-033 RST asserted asynchronously in the middle of cycle 2 of a MEM_LAT=3 WRITEBACK: all outputs drop to 0 at once, with no REG_WRITE pulse. After RST release, cycle 1 of FETCH shows MEM_READ1=1.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER control-unit types: instruction opcodes, control FSM states and strobe bundle.
// Build option CU_INTERRUPT_EN adds the TRAP state.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        EXEC      = 2'd1,
        WRITEBACK = 2'd2
`ifdef CU_INTERRUPT_EN
        ,
        TRAP      = 2'd3
`endif
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic reg_write;
        logic mem_write;
        logic mem_read1;
        logic mem_read2;
        logic csr_write;
        logic int_taken;
        logic illegal_op;
    } ctrl_t;

    // Wait counter must hold 0..MEM_LAT-1.
    function automatic int cnt_width(input int mem_lat);
        return $clog2(mem_lat) + 1;
    endfunction

endpackage

// File: rtl/cu_wait_cnt.sv
// Memory-latency wait counter for the multicycle control unit; done marks the last
// cycle of a MEM_LAT-long phase.
module cu_wait_cnt
    import otter_pkg::*;
#(
    parameter  int MEM_LAT = 1,
    localparam int CNT_W   = cnt_width(MEM_LAT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/cu_fsm_mc.sv
// Multicycle control unit FSM: FETCH -> EXEC -> (WRITEBACK) -> [TRAP] -> FETCH.
// Define CU_INTERRUPT_EN to enable interrupt entry through the TRAP state.
module cu_fsm_mc
    import otter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] CU_OPCODE,
    input  logic       INT,
    input  logic       CSR_MIE,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_WRITE,
    output logic       MEM_READ1,
    output logic       MEM_READ2,
    output logic       CSR_WRITE,
    output logic       INT_TAKEN,
    output logic       ILLEGAL_OP
);

    localparam int CNT_W = cnt_width(MEM_LAT);

    state_t           state;
    state_t           next_state;
    state_t           complete_next;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_unused;
    logic             is_load;
    ctrl_t            ctrl;

    cu_wait_cnt #(
        .MEM_LAT(MEM_LAT)
    ) u_wait_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clear (cnt_clear),
        .enable(cnt_enable),
        .count (cnt_unused),
        .done  (cnt_done)
    );

    assign is_load = (CU_OPCODE == LOAD);

    // Interrupt is sampled only where an instruction completes; nothing is latched.
`ifdef CU_INTERRUPT_EN
    assign complete_next = (INT & CSR_MIE) ? TRAP : FETCH;
`else
    logic int_unused;
    assign int_unused    = INT ^ CSR_MIE;
    assign complete_next = FETCH;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            FETCH: begin
                cnt_enable = 1'b1;
                if (cnt_done) begin
                    cnt_clear  = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                cnt_clear  = 1'b1;
                next_state = is_load ? WRITEBACK : complete_next;
            end
            WRITEBACK: begin
                if (cnt_done) begin
                    cnt_clear  = 1'b1;
                    next_state = complete_next;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
`ifdef CU_INTERRUPT_EN
            TRAP:    next_state = FETCH;
`endif
            default: next_state = FETCH;
        endcase
    end

    // NOTE: strobes are gated by RST combinationally so they drop the instant reset
    // asserts, without waiting for a clock edge.
    always_comb begin
        ctrl = '0;
        if (!RST) begin
            case (state)
                FETCH: ctrl.mem_read1 = 1'b1;
                EXEC: begin
                    case (CU_OPCODE)
                        LUI, AUIPC, JAL, JALR, OP, OP_IMM: begin
                            ctrl.reg_write = 1'b1;
                            ctrl.pc_write  = 1'b1;
                        end
                        BRANCH: ctrl.pc_write = 1'b1;
                        STORE: begin
                            ctrl.mem_write = 1'b1;
                            ctrl.pc_write  = 1'b1;
                        end
                        SYSTEM: begin
                            ctrl.csr_write = 1'b1;
                            ctrl.reg_write = 1'b1;
                            ctrl.pc_write  = 1'b1;
                        end
                        LOAD: ctrl.mem_read2 = 1'b1;
                        default: begin
                            ctrl.illegal_op = 1'b1;
                            ctrl.pc_write   = 1'b1;
                        end
                    endcase
                end
                WRITEBACK: begin
                    if (cnt_done) begin
                        ctrl.reg_write = 1'b1;
                        ctrl.pc_write  = 1'b1;
                    end else begin
                        ctrl.mem_read2 = 1'b1;
                    end
                end
`ifdef CU_INTERRUPT_EN
                TRAP: begin
                    ctrl.int_taken = 1'b1;
                    ctrl.pc_write  = 1'b1;
                end
`endif
                default: ctrl = '0;
            endcase
        end
    end

    assign PC_WRITE   = ctrl.pc_write;
    assign REG_WRITE  = ctrl.reg_write;
    assign MEM_WRITE  = ctrl.mem_write;
    assign MEM_READ1  = ctrl.mem_read1;
    assign MEM_READ2  = ctrl.mem_read2;
    assign CSR_WRITE  = ctrl.csr_write;
    assign INT_TAKEN  = ctrl.int_taken;
    assign ILLEGAL_OP = ctrl.illegal_op;

endmodule
